// File: rtl/emmc_dev_cmd.sv
//==============================================================================
// Module      : emmc_dev_cmd
// Description : Device-side eMMC CMD-line engine. Receives 48-bit host command
//               frames (start/transmission/index/argument/CRC7/end), flags CRC
//               or end-bit errors, presents index and argument to device logic,
//               then serialises the R1/R3/R2 response that device logic offers
//               once the NCR gap has elapsed.
// Ports       : clk_core, rst_tk          - card clock, async active-high reset
//               cmd_i / cmd_o / cmd_oe_o  - sampled CMD line, drive value/enable
//               cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_err_o - received command
//               resp_valid_i, resp_ready_o, resp_type_i, resp_idx_i,
//               resp_arg_i, resp_long_i   - response handshake and payload
//               timeout_o, busy_o         - NCR timeout pulse, engine busy
// Options     : EMMC_DEV_CRC_INJ_EN - adds crc_inj_i; when set at accept with
//               an R1 response the CRC7 LSB is inverted on the line.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module emmc_dev_cmd #(
    parameter int NCR_MIN = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         clk_core,
    input  logic         rst_tk,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    output logic         cmd_err_o,
    input  logic         resp_valid_i,
    output logic         resp_ready_o,
    input  logic [1:0]   resp_type_i,
    input  logic [5:0]   resp_idx_i,
    input  logic [31:0]  resp_arg_i,
    input  logic [126:0] resp_long_i,
`ifdef EMMC_DEV_CRC_INJ_EN
    input  logic         crc_inj_i,
`endif
    output logic         timeout_o,
    output logic         busy_o
);

    localparam logic [7:0] NCR_MIN_C = 8'(NCR_MIN);
    localparam logic [7:0] NCR_MAX_C = 8'(NCR_MAX);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RX        = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_TX        = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [5:0]     rx_cnt;     // index of the bit being sampled, counted from the start bit
    logic [44:0]    rx_sr;      // holds frame bits 45..1 when the end bit arrives
    logic [6:0]     rx_crc;
    logic [7:0]     ncr_cnt;
    logic [135:0]   tx_sr;      // response frame, left aligned, MSB on the line
    logic [7:0]     tx_cnt;
    logic [7:0]     tx_last;
    logic           tx_is_r1;
    logic [6:0]     tx_crc;
    logic           tx_inj;

    logic           accept;
    logic           rx_abort;
    logic           rx_done;
    logic           tx_done;
    logic           tx_bit;

    // CRC7, polynomial x^7 + x^3 + 1, one bit per call, MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    assign resp_ready_o = (state == ST_WAIT_RESP) && (ncr_cnt >= NCR_MIN_C);
    assign accept       = resp_valid_i && resp_ready_o;
    assign timeout_o    = (state == ST_WAIT_RESP) && (ncr_cnt >= NCR_MAX_C) && !accept;
    assign rx_abort     = (state == ST_RX) && (rx_cnt == 6'd1) && !cmd_i;
    assign rx_done      = (state == ST_RX) && (rx_cnt == 6'd47);
    assign tx_done      = (state == ST_TX) && (tx_cnt == tx_last);
    assign busy_o       = (state != ST_IDLE);

    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_bit    = tx_sr[135];
        cmd_oe_o  = 1'b0;
        cmd_o     = 1'b1;

        // R1 CRC field comes from the running CRC, which is complete by bit 40
        if (tx_is_r1 && (tx_cnt >= 8'd40) && (tx_cnt <= 8'd46)) begin
            tx_bit = tx_crc[6] ^ (tx_inj && (tx_cnt == 8'd46));
        end

        case (state)
            ST_IDLE: begin
                if (!cmd_i) begin
                    state_nxt = ST_RX;
                end
            end
            ST_RX: begin
                if (rx_abort) begin
                    state_nxt = ST_IDLE;
                end else if (rx_done) begin
                    state_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (accept) begin
                    state_nxt = (resp_type_i == 2'd0) ? ST_IDLE : ST_TX;
                end else if (timeout_o) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TX: begin
                cmd_oe_o = 1'b1;
                cmd_o    = tx_bit;
                if (tx_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            cmd_valid_o <= 1'b0;
            cmd_idx_o   <= '0;
            cmd_arg_o   <= '0;
            cmd_err_o   <= 1'b0;
            rx_cnt      <= 6'd1;
            rx_sr       <= '0;
            rx_crc      <= '0;
            ncr_cnt     <= '0;
            tx_sr       <= '0;
            tx_cnt      <= '0;
            tx_last     <= 8'd47;
            tx_is_r1    <= 1'b0;
            tx_crc      <= '0;
            tx_inj      <= 1'b0;
        end else begin
            cmd_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start bit is zero, so a zero-initialised CRC is unchanged by it
                    rx_cnt <= 6'd1;
                    rx_crc <= '0;
                end
                ST_RX: begin
                    rx_cnt <= rx_cnt + 6'd1;
                    rx_sr  <= {rx_sr[43:0], cmd_i};
                    if (rx_cnt <= 6'd39) begin
                        rx_crc <= crc7_step(rx_crc, cmd_i);
                    end
                    if (rx_done) begin
                        cmd_valid_o <= 1'b1;
                        cmd_idx_o   <= rx_sr[44:39];
                        cmd_arg_o   <= rx_sr[38:7];
                        cmd_err_o   <= (rx_crc != rx_sr[6:0]) || !cmd_i;
                        ncr_cnt     <= '0;
                    end
                end
                ST_WAIT_RESP: begin
                    if (ncr_cnt != 8'hFF) begin
                        ncr_cnt <= ncr_cnt + 8'd1;
                    end
                    if (accept) begin
                        tx_cnt   <= '0;
                        tx_crc   <= '0;
                        tx_is_r1 <= (resp_type_i == 2'd1);
                        tx_last  <= (resp_type_i == 2'd3) ? 8'd135 : 8'd47;
`ifdef EMMC_DEV_CRC_INJ_EN
                        tx_inj   <= crc_inj_i && (resp_type_i == 2'd1);
`else
                        tx_inj   <= 1'b0;
`endif
                        case (resp_type_i)
                            2'd1:    tx_sr <= {2'b00, resp_idx_i, resp_arg_i, 7'h00, 1'b1, 88'd0};
                            2'd2:    tx_sr <= {2'b00, 6'h3F, resp_arg_i, 7'h7F, 1'b1, 88'd0};
                            default: tx_sr <= {2'b00, 6'h3F, resp_long_i, 1'b1};
                        endcase
                    end
                end
                ST_TX: begin
                    tx_sr  <= {tx_sr[134:0], 1'b0};
                    tx_cnt <= tx_cnt + 8'd1;
                    if (tx_cnt < 8'd40) begin
                        tx_crc <= crc7_step(tx_crc, tx_sr[135]);
                    end else begin
                        tx_crc <= {tx_crc[5:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_emmc_dev_cmd.sv
//==============================================================================
// Module      : tb_emmc_dev_cmd
// Description : Self-checking bench for emmc_dev_cmd. Host frames are driven
//               bit-serially, expected results are queued when stimulus is
//               issued and compared as the DUT produces them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_emmc_dev_cmd;

    localparam int NCR_MIN = 2;
    localparam int NCR_MAX = 64;

    logic         clk_core = 1'b0;
    logic         rst_tk;
    logic         cmd_i;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic         cmd_valid_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         cmd_err_o;
    logic         resp_valid_i;
    logic         resp_ready_o;
    logic [1:0]   resp_type_i;
    logic [5:0]   resp_idx_i;
    logic [31:0]  resp_arg_i;
    logic [126:0] resp_long_i;
    logic         timeout_o;
    logic         busy_o;
`ifdef EMMC_DEV_CRC_INJ_EN
    logic         crc_inj;
`endif

    emmc_dev_cmd #(
        .NCR_MIN (NCR_MIN),
        .NCR_MAX (NCR_MAX)
    ) dut (
        .clk_core     (clk_core),
        .rst_tk       (rst_tk),
        .cmd_i        (cmd_i),
        .cmd_o        (cmd_o),
        .cmd_oe_o     (cmd_oe_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_idx_o    (cmd_idx_o),
        .cmd_arg_o    (cmd_arg_o),
        .cmd_err_o    (cmd_err_o),
        .resp_valid_i (resp_valid_i),
        .resp_ready_o (resp_ready_o),
        .resp_type_i  (resp_type_i),
        .resp_idx_i   (resp_idx_i),
        .resp_arg_i   (resp_arg_i),
        .resp_long_i  (resp_long_i),
`ifdef EMMC_DEV_CRC_INJ_EN
        .crc_inj_i    (crc_inj),
`endif
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk_core = ~clk_core;

    int cyc = 0;
    always @(posedge clk_core) cyc <= cyc + 1;

    int valid_seen = 0;
    always @(negedge clk_core) if (cmd_valid_o) valid_seen <= valid_seen + 1;

    int n_checks = 0;
    int n_fail   = 0;

    string        tag_q[$];
    logic [135:0] exp_q[$];

    logic [135:0] cap_bits;
    int           cap_len;
    int           cap_start;
    int           c_end;
    int           vs;
    logic         oe_seen;
    logic [126:0] long_pat;
    logic [47:0]  fr;

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [135:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input logic [135:0] obs);
        string        t;
        logic [135:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected a pending entry");
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, obs, e);
        end
    endtask

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b01, idx, arg};
        return {d, crc7_model(d), 1'b1};
    endfunction

    function automatic logic [47:0] r1_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        d = {2'b00, idx, arg};
        return {d, crc7_model(d), 1'b1};
    endfunction

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    // c_end is the cycle in which the end bit was on the line
    task automatic send_frame(input logic [47:0] f);
        for (int b = 47; b >= 0; b--) begin
            cmd_i = f[b];
            step();
        end
        cmd_i = 1'b1;
        c_end = cyc - 1;
    endtask

    // Waits for the DUT to drive, then records every driven bit; payload
    // inputs are scrambled once driving starts since only the accept sample counts
    task automatic capture();
        cap_bits  = '0;
        cap_len   = 0;
        cap_start = 0;
        for (int i = 0; i < 300 && !cmd_oe_o; i++) step();
        if (!cmd_oe_o) return;
        cap_start    = cyc;
        resp_valid_i = 1'b0;
        resp_type_i  = 2'd0;
        resp_idx_i   = ~resp_idx_i;
        resp_arg_i   = ~resp_arg_i;
        resp_long_i  = ~resp_long_i;
`ifdef EMMC_DEV_CRC_INJ_EN
        crc_inj      = ~crc_inj;
`endif
        while (cmd_oe_o && cap_len < 200) begin
            cap_bits = {cap_bits[134:0], cmd_o};
            cap_len++;
            step();
        end
    endtask

    task automatic expect_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic err);
        push("cmd_valid", 1'b1);
        push("cmd_idx", idx);
        push("cmd_arg", arg);
        push("cmd_err", err);
    endtask

    task automatic pop_cmd();
        pop_check(cmd_valid_o);
        pop_check(cmd_idx_o);
        pop_check(cmd_arg_o);
        pop_check(cmd_err_o);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_tk       = 1'b1;
        cmd_i        = 1'b1;
        resp_valid_i = 1'b0;
        resp_type_i  = 2'd0;
        resp_idx_i   = '0;
        resp_arg_i   = '0;
        resp_long_i  = '0;
`ifdef EMMC_DEV_CRC_INJ_EN
        crc_inj      = 1'b0;
`endif
        repeat (3) step();

        // Reset values
        check("rst_ctl", {cmd_o, cmd_oe_o, cmd_valid_o, cmd_err_o, resp_ready_o, timeout_o, busy_o},
              7'b1000000);
        check("rst_idx", cmd_idx_o, 6'd0);
        check("rst_arg", cmd_arg_o, 32'd0);
        rst_tk = 1'b0;
        repeat (2) step();

        // CMD0, no response offered: NCR timeout
        expect_cmd(6'd0, 32'd0, 1'b0);
        send_frame(48'h40_00000000_95);
        pop_cmd();
        push("busy_wait", 1'b1);
        pop_check(busy_o);
        push("timeout_win", c_end + 1 + NCR_MAX);
        for (int i = 0; i < NCR_MAX + 16 && !timeout_o; i++) step();
        pop_check(timeout_o ? cyc : 0);
        step();
        push("post_timeout", 2'b00);
        pop_check({timeout_o, busy_o});

        // CMD17, R1 at first ready
        expect_cmd(6'd17, 32'd0, 1'b0);
        send_frame(48'h51_00000000_55);
        pop_cmd();
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd1;
        resp_idx_i   = 6'd17;
        resp_arg_i   = 32'h0000_0900;
        push("r1_start", c_end + NCR_MIN + 2);
        push("r1_len", 48);
        push("r1_frame", r1_frame(6'd17, 32'h0000_0900));
        push("r1_release", 3'b001);
        capture();
        pop_check(cap_start);
        pop_check(cap_len);
        pop_check(cap_bits);
        pop_check({cmd_oe_o, busy_o, cmd_o});

        // CMD17 with corrupted CRC, type 0 reply
        expect_cmd(6'd17, 32'd0, 1'b1);
        send_frame(48'h51_00000000_57);
        pop_cmd();
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd0;
        oe_seen      = 1'b0;
        push("t0_idle_win", c_end + NCR_MIN + 2);
        push("t0_no_drive", 1'b0);
        for (int i = 0; i < 40 && busy_o; i++) begin
            step();
            oe_seen = oe_seen | cmd_oe_o;
        end
        pop_check(busy_o ? 0 : cyc);
        pop_check(oe_seen);
        resp_valid_i = 1'b0;

        // Transmission bit 0: frame abandoned
        vs = valid_seen;
        send_frame(48'h3F_FFFFFFFF_FF);
        repeat (3) step();
        push("abort_no_valid", 0);
        push("abort_idle", 1'b0);
        pop_check(valid_seen - vs);
        pop_check(busy_o);

        // CMD1 then R3
        expect_cmd(6'd1, 32'h40FF_8080, 1'b0);
        send_frame(make_cmd(6'd1, 32'h40FF_8080));
        pop_cmd();
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd2;
        resp_arg_i   = 32'h80FF_8080;
        push("r3_len", 48);
        push("r3_frame", {2'b00, 6'h3F, 32'h80FF_8080, 7'h7F, 1'b1});
        capture();
        pop_check(cap_len);
        pop_check(cap_bits);

        // CMD0 then R2 with 5A pattern
        expect_cmd(6'd0, 32'd0, 1'b0);
        send_frame(48'h40_00000000_95);
        pop_cmd();
        long_pat     = {16{8'h5A}};
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd3;
        resp_long_i  = long_pat;
        push("r2_len", 136);
        push("r2_frame", {2'b00, 6'h3F, long_pat, 1'b1});
        push("r2_hdr", 6'h3F);
        capture();
        pop_check(cap_len);
        pop_check(cap_bits);
        pop_check(cap_bits[133:128]);

`ifdef EMMC_DEV_CRC_INJ_EN
        // Injected CRC error on R1: only the CRC LSB (frame bit 1) differs
        fr = make_cmd(6'd17, 32'h0000_0000);
        send_frame(fr);
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd1;
        resp_idx_i   = 6'd17;
        resp_arg_i   = 32'h0000_0900;
        crc_inj      = 1'b1;
        push("inj_len", 48);
        push("inj_frame", r1_frame(6'd17, 32'h0000_0900) ^ 48'h2);
        capture();
        crc_inj = 1'b0;
        pop_check(cap_len);
        pop_check(cap_bits);
`endif

        // Asynchronous reset in the middle of a response
        fr = 48'h51_00000000_55;
        send_frame(fr);
        resp_valid_i = 1'b1;
        resp_type_i  = 2'd1;
        resp_idx_i   = 6'd17;
        resp_arg_i   = 32'h1234_5678;
        for (int i = 0; i < 20 && !cmd_oe_o; i++) step();
        resp_valid_i = 1'b0;
        repeat (10) step();
        push("midtx_driving", 1'b1);
        pop_check(cmd_oe_o);
        #2 rst_tk = 1'b1;
        #1;
        push("midtx_reset", 3'b010);
        pop_check({cmd_oe_o, cmd_o, busy_o});
        step();
        rst_tk = 1'b0;
        repeat (2) step();
        expect_cmd(6'd0, 32'd0, 1'b0);
        send_frame(48'h40_00000000_95);
        pop_cmd();

        push("queue_drained", 0);
        pop_check(exp_q.size() - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
